n_bit_adder_reg: RTL and testbench
==================================

Name: n_bit_adder_reg

Overview:
- Parameterised N-bit binary adder with carry-in and an (N+1)-bit registered sum, so the carry-out is never lost.
- Built as a structural ripple-carry chain of 1-bit full-adder cells from a generate loop.
- A valid-qualified output register allows direct drop-in to clocked datapaths, e.g. accumulators and address/offset calculators.

Parameters:
- N, 8, operand width in bits; legal range N >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  N  operand A, unsigned.
- B  input  N  operand B, unsigned.
- C_In  input  1  carry-in, added at bit 0.
- in_valid  input  1  qualifies A/B/C_In this cycle.
- Out  output  N+1  registered sum; Out[N] is the carry-out.
- out_valid  output  1  high for one cycle per accepted input, aligned with the Out update.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Arithmetic: Out = A + B + C_In, computed at N+1 bits with zero-extension. No truncation and no wrap. The maximum is (2^N-1)*2+1 = 2^(N+1)-1.
- Datapath: ripple-carry chain.
  - Cell i: s_i = A[i]^B[i]^c_i, c_(i+1) = A[i]&B[i] | c_i&(A[i]^B[i]).
  - c_0 = C_In, and Out[N] = c_N.
  - The combinational sum is registered; no output is combinational.
- Latency: 1 cycle (base build). Inputs sampled at edge k appear on Out at edge k, visible after edge k, with out_valid=1 for that cycle.
- in_valid=0: the Out register holds its previous value and out_valid=0 next cycle.
- Back-to-back: in_valid high every cycle gives one result per cycle, with no bubbles.
- Reset: while rst=1 at a clock edge, Out <= 0 and out_valid <= 0. Reset has priority over in_valid.
- Reset mid-operation: any in-flight result is discarded. The first result after reset is from the first in_valid cycle with rst=0.
- X/unknown inputs while in_valid=0 must not corrupt Out.
- No backpressure and no ready signal. The consumer must take out_valid pulses as they occur.

Optional Feature:
- Macro: ADDER_PIPE_SPLIT_EN.
- Defined: two-stage pipeline, latency 2.
  - Stage 1 adds the low L = N/2 bits (floor) with C_In.
  - Stage 1 registers the low sum, the carry c_L, the upper operand halves A[N-1:L] and B[N-1:L], and valid.
  - Stage 2 adds the upper halves with the registered c_L and registers the full Out and out_valid.
  - Throughput stays 1 result/cycle.
  - rst clears both stages' valid bits and Out. Stage-1 data registers may be cleared or not, but must never produce out_valid.
  - A bubble (in_valid=0) propagates as out_valid=0 two cycles later while Out holds.
- Not defined: single-stage behaviour as above, latency 1.
- The arithmetic result is identical in both builds.

Test Plan:
- N=8: A=0xFF, B=0x01, C_In=0, in_valid=1 -> after latency, Out=0x100, out_valid=1 for exactly one cycle.
- N=8: A=0xFF, B=0xFF, C_In=1 -> Out=0x1FF (max). Then A=0x00, B=0x00, C_In=1 -> Out=0x001. Then A=0x00, B=0x00, C_In=0 -> Out=0x000.
- Carry ripple: A=0x0F, B=0x01, C_In=0 -> Out=0x010. A=0x7F, B=0x00, C_In=1 -> Out=0x080. The second case crosses the L=4 split boundary in the pipelined build.
- Hold/bubble: apply 0x12+0x34+0 with valid, then 3 cycles in_valid=0 with random A/B -> Out stays 0x046 and out_valid=0 during the bubble cycles.
- Reset: stream valid inputs, assert rst for 1 cycle mid-stream -> next edge Out=0 and out_valid=0. The in-flight result is not emitted; the first post-reset valid input yields its correct sum after the normal latency.
- Random: 50+ vectors of random A, B, C_In with in_valid=1 every cycle -> each Out equals the zero-extended A+B+C_In of the vector one latency earlier. Run in both macro builds and with N=8 and N=5.

Source files
------------

// File: rtl/n_bit_adder_reg_if.sv
// -----------------------------------------------------------------------------
// n_bit_adder_reg_if
//   Operand/result bundle for the registered N-bit adder.
//
//   Signals:
//     A, B      [N-1:0]  unsigned operands
//     C_In               carry-in, added at bit 0
//     in_valid           qualifies A/B/C_In in the current cycle
//     Out       [N:0]    registered sum, Out[N] is the carry-out
//     out_valid          one-cycle pulse per accepted input, aligned with Out
//
//   Modports:
//     master  - producer of operands, consumer of results (e.g. a testbench)
//     slave   - the adder itself
// -----------------------------------------------------------------------------
interface n_bit_adder_reg_if #(
  parameter int N = 8
);
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         C_In;
  logic         in_valid;
  logic [N:0]   Out;
  logic         out_valid;

  modport master (
    output A, B, C_In, in_valid,
    input  Out, out_valid
  );

  modport slave (
    input  A, B, C_In, in_valid,
    output Out, out_valid
  );
endinterface

// File: rtl/n_bit_adder_reg.sv
// -----------------------------------------------------------------------------
// n_bit_adder_reg
//   N-bit unsigned ripple-carry adder with carry-in and a registered (N+1)-bit
//   sum, so the carry-out is never lost: Out = A + B + C_In.
//
//   Ports:
//     clk  - system clock, all state updates on the rising edge
//     rst  - synchronous, active-high reset (clears Out and out_valid)
//     bus  - n_bit_adder_reg_if.slave: A, B, C_In, in_valid in; Out, out_valid out
//
//   Build option:
//     ADDER_PIPE_SPLIT_EN undefined : single register stage, latency 1.
//     ADDER_PIPE_SPLIT_EN defined   : two stages split at L = N/2, latency 2.
//       Stage 1 adds the low L bits with C_In and captures the carry c_L and
//       the upper operand halves; stage 2 finishes the upper bits.
//   Both builds give one result per cycle and identical arithmetic. Out holds
//   its value whenever no result is delivered.
// -----------------------------------------------------------------------------
module n_bit_adder_reg #(
  parameter int N = 8
) (
  input logic               clk,
  input logic               rst,
  n_bit_adder_reg_if.slave  bus
);

  localparam int L = N / 2;

  // Operands actually seen by the carry chain. In the split build the upper
  // half comes from the stage-1 registers, the lower half straight from bus.
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] s;
  logic [N:0]   c;
  logic         hi_cin;   // carry entering cell L

  logic [N:0]   out_d, out_q;
  logic         vld_d, vld_q;

  // ---------------------------------------------------------------------------
  // Structural ripple-carry chain of 1-bit full-adder cells.
  // Cell L takes hi_cin instead of c[L]: in the single-stage build the two are
  // the same wire, in the split build hi_cin is the registered c_L.
  // ---------------------------------------------------------------------------
  assign c[0] = bus.C_In;

  for (genvar i = 0; i < N; i++) begin : g_cell
    logic cin;
    if (i == L) begin : g_split
      assign cin = hi_cin;
    end else begin : g_chain
      assign cin = c[i];
    end
    assign s[i]   = op_a[i] ^ op_b[i] ^ cin;
    assign c[i+1] = (op_a[i] & op_b[i]) | (cin & (op_a[i] ^ op_b[i]));
  end

`ifdef ADDER_PIPE_SPLIT_EN
  // ---------------------------------------------------------------------------
  // Stage 1: low sum, carry c_L, upper operand halves, valid.
  // ---------------------------------------------------------------------------
  logic [L-1:0]   lo_d, lo_q;
  logic           cl_d, cl_q;
  logic [N-L-1:0] a_hi_d, a_hi_q;
  logic [N-L-1:0] b_hi_d, b_hi_q;
  logic           v1_d, v1_q;

  assign op_a   = {a_hi_q, bus.A[L-1:0]};
  assign op_b   = {b_hi_q, bus.B[L-1:0]};
  assign hi_cin = cl_q;

  // NOTE: every output of an always_comb gets a default first (here: hold the
  // current value) so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    v1_d   = bus.in_valid;
    lo_d   = lo_q;
    cl_d   = cl_q;
    a_hi_d = a_hi_q;
    b_hi_d = b_hi_q;
    if (bus.in_valid) begin
      lo_d   = s[L-1:0];
      cl_d   = c[L];
      a_hi_d = bus.A[N-1:L];
      b_hi_d = bus.B[N-1:L];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) v1_q <= 1'b0;
    else     v1_q <= v1_d;
  end

  // NOTE: stage-1 data registers carry no reset; they are only ever consumed
  // when v1_q is set, and v1_q is cleared by reset.
  always_ff @(posedge clk) begin
    lo_q   <= lo_d;
    cl_q   <= cl_d;
    a_hi_q <= a_hi_d;
    b_hi_q <= b_hi_d;
  end

  // Stage 2: finish the upper bits and assemble the full result.
  always_comb begin
    vld_d = v1_q;
    out_d = out_q;
    if (v1_q) out_d = {c[N], s[N-1:L], lo_q};
  end
`else
  // ---------------------------------------------------------------------------
  // Single stage: whole chain is combinational from the inputs.
  // ---------------------------------------------------------------------------
  assign op_a   = bus.A;
  assign op_b   = bus.B;
  assign hi_cin = c[L];

  always_comb begin
    vld_d = bus.in_valid;
    out_d = out_q;
    if (bus.in_valid) out_d = {c[N], s};
  end
`endif

  // ---------------------------------------------------------------------------
  // Output register; reset wins over any valid input or in-flight result.
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign bus.Out       = out_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_n_bit_adder_reg.sv
// -----------------------------------------------------------------------------
// tb_n_bit_adder_reg
//   Scoreboard bench for n_bit_adder_reg. The stimulus process pushes the
//   expected sum for every accepted input; a monitor on the falling edge pops
//   and compares whenever out_valid is high, and otherwise checks that Out
//   holds the last delivered value (or zero after reset).
//   Directed vectors carry hand-computed sums for N=8; other widths fall back
//   to a zero-extended behavioural sum.
// -----------------------------------------------------------------------------
module tb_n_bit_adder_reg;

  parameter int N = 8;

`ifdef ADDER_PIPE_SPLIT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  n_bit_adder_reg_if #(.N(N)) bus ();

  n_bit_adder_reg #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [N:0] exp_q[$];
  logic [N:0] held = '0;
  logic       rst_sampled = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic cin);
    model = ({1'b0, a} + {1'b0, b}) + {{N{1'b0}}, cin};
  endfunction

  // Hand value when the table was written for this width, model otherwise.
  function automatic logic [N:0] expect_of(input vec_t v);
    if (N == 8) expect_of = v.e[N:0];
    else        expect_of = model(v.a[N-1:0], v.b[N-1:0], v.c);
  endfunction

  // Reset discards everything in flight, so flush the scoreboard on the edge.
  always @(posedge clk) begin
    rst_sampled = rst;
    if (rst) exp_q.delete();
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [N:0] e;
    if (rst_sampled) begin
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out", 64'(bus.Out), 64'd0);
      held = '0;
    end else if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(bus.out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum", 64'(bus.Out), 64'(e));
        held = e;
      end
    end else begin
      check("idle_out_valid", 64'(bus.out_valid), 64'd0);
      check("hold_out", 64'(bus.Out), 64'(held));
    end
  end

  // Apply one cycle of inputs; the result is queued only if it will be accepted.
  task automatic step(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                      input logic v, input logic r, input logic [N:0] e);
    bus.A        = a;
    bus.B        = b;
    bus.C_In     = cin;
    bus.in_valid = v;
    rst          = r;
    if (v && !r) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step_vec(input vec_t v, input logic r);
    step(v.a[N-1:0], v.b[N-1:0], v.c, 1'b1, r, expect_of(v));
  endtask

  vec_t dir_tab[7] = '{
    '{32'hFF, 32'h01, 1'b0, 32'h100},  // carry-out only
    '{32'hFF, 32'hFF, 1'b1, 32'h1FF},  // maximum
    '{32'h00, 32'h00, 1'b1, 32'h001},  // carry-in only
    '{32'h00, 32'h00, 1'b0, 32'h000},  // zero
    '{32'h0F, 32'h01, 1'b0, 32'h010},  // ripple through low nibble
    '{32'h7F, 32'h00, 1'b1, 32'h080},  // ripple across the L=4 split
    '{32'h12, 32'h34, 1'b0, 32'h046}   // value held through the bubble
  };

  vec_t rst_tab[6] = '{
    '{32'h01, 32'h02, 1'b0, 32'h003},
    '{32'h10, 32'h20, 1'b1, 32'h031},
    '{32'h80, 32'h80, 1'b0, 32'h100},
    '{32'hAA, 32'h55, 1'b0, 32'h0FF},  // applied with rst=1: must be dropped
    '{32'h55, 32'hAA, 1'b1, 32'h100},
    '{32'h3C, 32'hC3, 1'b0, 32'h0FF}
  };

  initial begin
    logic [N-1:0] ra, rb;
    logic         rc;

    bus.A        = '0;
    bus.B        = '0;
    bus.C_In     = 1'b0;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Directed arithmetic, back to back.
    for (int i = 0; i < 7; i++) step_vec(dir_tab[i], 1'b0);

    // Bubble: random and unknown operands with in_valid low must not disturb Out.
    step(N'($urandom), N'($urandom), 1'b1, 1'b0, 1'b0, '0);
    step('x, 'x, 1'bx, 1'b0, 1'b0, '0);
    step(N'($urandom), N'($urandom), 1'b0, 1'b0, 1'b0, '0);
    repeat (LAT) step('0, '0, 1'b0, 1'b0, 1'b0, '0);

    // Reset in the middle of a stream.
    for (int i = 0; i < 6; i++) step_vec(rst_tab[i], (i == 3) ? 1'b1 : 1'b0);

    // Random back-to-back stream.
    for (int i = 0; i < 60; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rc = 1'($urandom_range(0, 1));
      step(ra, rb, rc, 1'b1, 1'b0, model(ra, rb, rc));
    end

    // Drain and confirm every queued result came out.
    repeat (LAT + 3) step('0, '0, 1'b0, 1'b0, 1'b0, '0);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog timeout");
  end

endmodule
